// File: rtl/sdc_spi_cmd.sv
// SD-card SPI command engine: frames one 48-bit command, polls for R1, captures R1 plus up to 4 trailing bytes.
// Latency: (8 pre + 48 cmd + W ncr + 7 r1 + 8*len resp + 8 tail) slots of 2*CLK_DIV cycles, then a one-cycle done.
// Backpressure: none; i_we is accepted only in IDLE and strobes while busy are dropped. Optional CRC7 generator: SDC_SPI_CMD_CRC7_EN.
module sdc_spi_cmd #(
  parameter int CLK_DIV = 2,
  parameter int NCR_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_cmd,
  input  logic [31:0] i_arg,
  input  logic [7:0]  i_crc,
  input  logic [2:0]  i_resp_len,
  input  logic        i_we,
  input  logic        i_miso,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_cs,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [7:0]  o_r1,
  output logic [31:0] o_resp
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_CMD, S_NCR, S_R1, S_RESP, S_TAIL, S_DONE
  } state_t;

  localparam logic [8:0]  DIV_HALF = 9'(CLK_DIV);
  localparam logic [8:0]  DIV_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [10:0] NCR_LAST = 11'(8 * NCR_MAX - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [8:0]   r_div;
  logic [10:0]  r_cnt;
  logic [47:0]  r_shift;
  logic [2:0]   r_len;
  logic [7:0]   r_r1;
  logic [31:0]  r_resp;
  logic         r_timeout;
  logic         r_found;

  logic         w_active;
  logic         w_slot_end;
  logic         w_sample;
  logic         w_start_bit;
  logic         w_accept;
  logic [10:0]  w_resp_last;

`ifdef SDC_SPI_CMD_CRC7_EN
  logic [6:0]   r_crc;
  logic [6:0]   w_crc_nxt;
  // CRC7 (x^7+x^3+1) advanced by the bit currently on MOSI
  assign w_crc_nxt = {r_crc[5:0], 1'b0} ^ ({7{r_shift[47] ^ r_crc[6]}} & 7'h09);
`endif

  // SCK runs in every state that owns bit slots; TAIL clocks with CS high
  assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_slot_end  = w_active && (r_div == DIV_LAST);
  assign w_sample    = w_active && (r_div == DIV_HALF);
  // Start bit may be seen on the same cycle as the slot end when CLK_DIV=1
  assign w_start_bit = (r_state == S_NCR) && (r_found || (w_sample && !i_miso));
  assign w_resp_last = {5'd0, r_len - 3'd1, 3'b111};

  assign o_r1   = r_r1;
  assign o_resp = r_resp;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and pin/status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    o_cs        = 1'b1;
    o_mosi      = 1'b1;
    o_done      = 1'b0;
    o_timeout   = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_sck       = w_active && (r_div >= DIV_HALF);
    case (r_state)
      S_IDLE: begin
        if (i_we) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        o_cs = 1'b0;
        if (w_slot_end && r_cnt == 11'd7) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        o_cs   = 1'b0;
        o_mosi = r_shift[47];
        if (w_slot_end && r_cnt == 11'd47) w_state_nxt = S_NCR;
      end
      S_NCR: begin
        o_cs = 1'b0;
        if (w_slot_end) begin
          if (w_start_bit)            w_state_nxt = S_R1;
          else if (r_cnt == NCR_LAST) w_state_nxt = S_TAIL;
        end
      end
      S_R1: begin
        o_cs = 1'b0;
        if (w_slot_end && r_cnt == 11'd6)
          w_state_nxt = (r_len != 3'd0) ? S_RESP : S_TAIL;
      end
      S_RESP: begin
        o_cs = 1'b0;
        if (w_slot_end && r_cnt == w_resp_last) w_state_nxt = S_TAIL;
      end
      S_TAIL: begin
        if (w_slot_end && r_cnt == 11'd7) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        o_timeout   = r_timeout;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slot timing, command shifter and response capture
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div     <= '0;
      r_cnt     <= '0;
      r_shift   <= '1;
      r_len     <= '0;
      r_r1      <= 8'hFF;
      r_resp    <= '0;
      r_timeout <= 1'b0;
      r_found   <= 1'b0;
`ifdef SDC_SPI_CMD_CRC7_EN
      r_crc     <= '0;
`endif
    end else begin
      if (w_active) r_div <= w_slot_end ? 9'd0 : r_div + 9'd1;
      else          r_div <= '0;

      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_slot_end)        r_cnt <= r_cnt + 11'd1;

      if (w_accept) begin
        r_shift   <= {i_cmd, i_arg, i_crc};
        r_len     <= (i_resp_len > 3'd4) ? 3'd4 : i_resp_len;
        r_r1      <= 8'hFF;
        r_timeout <= 1'b0;
        r_found   <= 1'b0;
`ifdef SDC_SPI_CMD_CRC7_EN
        r_crc     <= '0;
`endif
      end

      if (r_state == S_CMD && w_slot_end) begin
`ifdef SDC_SPI_CMD_CRC7_EN
        if (r_cnt < 11'd40) r_crc <= w_crc_nxt;
        // After the last argument bit the CRC byte slides in behind it
        if (r_cnt == 11'd39) r_shift <= {w_crc_nxt, 1'b1, r_shift[38:0], 1'b1};
        else                 r_shift <= {r_shift[46:0], 1'b1};
`else
        r_shift <= {r_shift[46:0], 1'b1};
`endif
      end

      if (r_state == S_NCR) begin
        if (w_sample && !i_miso && !r_found) begin
          r_r1    <= 8'hFE;
          r_found <= 1'b1;
        end
        if (w_state_nxt == S_TAIL) r_timeout <= 1'b1;
      end

      if (r_state == S_R1 && w_sample) r_r1 <= {r_r1[6:0], i_miso};
      if (r_state == S_R1 && w_state_nxt == S_RESP) r_resp <= '0;
      if (r_state == S_RESP && w_sample) r_resp <= {r_resp[30:0], i_miso};
    end
  end

endmodule

// File: tb/tb_sdc_spi_cmd.sv
// Directed bench for sdc_spi_cmd with a bit-level SD card responder model.
module tb_sdc_spi_cmd;
  localparam int CLK_DIV = 2;
  localparam int NCR_MAX = 8;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_cmd = 8'h00;
  logic [31:0] i_arg = 32'h0;
  logic [7:0]  i_crc = 8'h00;
  logic [2:0]  i_resp_len = 3'd0;
  logic        i_we = 1'b0;
  logic        i_miso = 1'b1;
  logic        o_sck, o_mosi, o_cs, o_busy, o_done, o_timeout;
  logic [7:0]  o_r1;
  logic [31:0] o_resp;

  int n_chk = 0;
  int n_err = 0;

  // Card model state: response stream starts at the first NCR slot (slot 56)
  logic [127:0] card_bits = '0;
  int           card_nbits = 0;
  int           slot = 0;
  logic         prev_sck = 1'b0;
  logic [47:0]  frame = '0;
  int           done_cnt = 0;
  int           cs_lo_sck = 0;
  int           tail_sck = 0;

  sdc_spi_cmd #(.CLK_DIV(CLK_DIV), .NCR_MAX(NCR_MAX)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_cmd(i_cmd), .i_arg(i_arg), .i_crc(i_crc),
    .i_resp_len(i_resp_len), .i_we(i_we), .i_miso(i_miso),
    .o_sck(o_sck), .o_mosi(o_mosi), .o_cs(o_cs), .o_busy(o_busy), .o_done(o_done),
    .o_timeout(o_timeout), .o_r1(o_r1), .o_resp(o_resp)
  );

  always #5 clk = ~clk;

  function automatic logic stream_bit(input int k);
    if (k < 0 || k >= card_nbits) return 1'b1;
    return card_bits[127 - k];
  endfunction

  // Card side: MISO changes on SCK fall, MOSI captured on SCK rise
  always @(negedge clk) begin
    if (o_cs) begin
      slot   = 0;
      i_miso = 1'b1;
      if (o_busy && !prev_sck && o_sck) tail_sck++;
    end else begin
      if (prev_sck && !o_sck) begin
        slot++;
        i_miso = stream_bit(slot - 56);
      end
      if (!prev_sck && o_sck) begin
        cs_lo_sck++;
        if (slot >= 8 && slot < 56) frame = {frame[46:0], o_mosi};
      end
    end
    prev_sck = o_sck;
    if (o_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [31:0] arg,
                         input logic [7:0] crc, input logic [2:0] len,
                         input logic [127:0] bits, input int nbits, input int exp_w,
                         input logic exp_to, input logic [7:0] exp_r1,
                         input logic [31:0] exp_resp, input logic [47:0] exp_frame,
                         input logic [47:0] frame_mask);
    int lat, elen, exp_lat, exp_lo, d0, lo0, t0;
    elen    = (len > 3'd4) ? 4 : int'(len);
    exp_lat = exp_to ? (8 + 48 + 8*NCR_MAX + 8) * 2 * CLK_DIV
                     : (8 + 48 + exp_w + 7 + 8*elen + 8) * 2 * CLK_DIV;
    exp_lo  = exp_to ? (56 + 8*NCR_MAX) : (56 + exp_w + 7 + 8*elen);
    d0 = done_cnt; lo0 = cs_lo_sck; t0 = tail_sck;
    card_bits  = bits;
    card_nbits = nbits;
    @(negedge clk);
    i_cmd = cmd; i_arg = arg; i_crc = crc; i_resp_len = len; i_we = 1'b1;
    @(posedge clk); #1;
    i_we = 1'b0;
    chk({tag, "_start"}, {62'd0, o_busy, o_cs}, 64'b10);
    lat = 0;
    while (!o_done && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_timeout"}, {63'd0, o_timeout}, {63'd0, exp_to});
    chk({tag, "_r1"}, {56'd0, o_r1}, {56'd0, exp_r1});
    if (!exp_to) chk({tag, "_resp"}, {32'd0, o_resp}, {32'd0, exp_resp});
    chk({tag, "_frame"}, {16'd0, frame & frame_mask}, {16'd0, exp_frame & frame_mask});
    @(posedge clk); #1;
    chk({tag, "_drop"}, {61'd0, o_busy, o_done, o_timeout}, 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_cs_low_sck"}, 64'(cs_lo_sck - lo0), 64'(exp_lo));
    chk({tag, "_tail_sck"}, 64'(tail_sck - t0), 64'd8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, d0;
    logic [7:0] cmd8_last;
`ifdef SDC_SPI_CMD_CRC7_EN
    cmd8_last = 8'h87;
`else
    cmd8_last = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins", {58'd0, o_cs, o_sck, o_mosi, o_busy, o_done, o_timeout}, 64'b101000);
    chk("rst_r1", {56'd0, o_r1}, 64'hFF);
    chk("rst_resp", {32'd0, o_resp}, 64'h0);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0: two idle bytes then R1=0x01, start bit at stream bit 16
    run_cmd("cmd0", 8'h40, 32'h0, 8'h95, 3'd0, {24'hFFFF01, 104'd0}, 24, 17,
            1'b0, 8'h01, 32'h0, 48'h40_00000000_95, 48'hFFFF_FFFF_FFFF);
    // CMD8 R7: one idle byte, R1=0x01, echo 0x000001AA
    run_cmd("cmd8", 8'h48, 32'h0000_01AA, 8'h00, 3'd4, {48'hFF01000001AA, 80'd0}, 48, 9,
            1'b0, 8'h01, 32'h0000_01AA, {8'h48, 32'h0000_01AA, cmd8_last}, 48'hFFFF_FFFF_FFFF);
    // No start bit ever: timeout after 8*NCR_MAX slots
    run_cmd("tmo", 8'h69, 32'h4000_0000, 8'h77, 3'd2, 128'd0, 0, 0,
            1'b1, 8'hFF, 32'h0, 48'h69_40000000_00, 48'hFFFF_FFFF_FF00);
    // Start bit in the first NCR slot, resp_len 7 clamps to 4
    run_cmd("w1", 8'h77, 32'h0, 8'h65, 3'd7, {40'h01DEADBEEF, 88'd0}, 40, 1,
            1'b0, 8'h01, 32'hDEAD_BEEF, 48'h77_00000000_00, 48'hFFFF_FFFF_FF00);

    // Strobe during CMD is ignored; reset during NCR aborts with no done
    d0 = done_cnt;
    card_bits = '0; card_nbits = 0;
    @(negedge clk);
    i_cmd = 8'h40; i_arg = 32'h0; i_crc = 8'h95; i_resp_len = 3'd0; i_we = 1'b1;
    @(negedge clk);
    i_we = 1'b0;
    g = 0;
    while (slot < 20 && g < 1000) begin @(negedge clk); g++; end
    chk("abort_reach_cmd", {63'd0, (slot >= 20)}, 64'd1);
    i_cmd = 8'h51; i_arg = 32'h1234_5678; i_crc = 8'h00; i_we = 1'b1;
    @(negedge clk);
    i_we = 1'b0;
    chk("abort_busy", {63'd0, o_busy}, 64'd1);
    g = 0;
    while (slot < 60 && g < 1000) begin @(negedge clk); g++; end
    chk("abort_reach_ncr", {63'd0, (slot >= 60)}, 64'd1);
    chk("abort_frame", {16'd0, frame}, {16'd0, 48'h40_00000000_95});
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_pins", {58'd0, o_cs, o_sck, o_mosi, o_busy, o_done, o_timeout}, 64'b101000);
    chk("abort_r1", {56'd0, o_r1}, 64'hFF);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (600) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_idle", {63'd0, o_busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
